// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and WIDTH legality check.
// Optional feature macro used by serial_adder: SERIAL_ADDER_OVF_EN (adds o_ovf).
`ifndef SERIAL_ADDER_PKG_SV
`define SERIAL_ADDER_PKG_SV

`define SERIAL_ADDER_WIDTH_OK(w) (((w) >= 2) && ((w) <= 64))

package serial_adder_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 64;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

`endif

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic cell of the serial datapath.
module fa_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: WIDTH bits LSB first through one fa_cell, carry kept in a flop.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output o_ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_sub,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             o_ovf,
`endif
   output state_t           o_dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_adder: WIDTH must be in 2..64");
   end

   // Handshake: i_start is sampled only while o_busy=0 (including the o_done cycle);
   // o_done is a one-cycle pulse coinciding with the update of o_sum/o_cout.
   state_t           r_state;
   state_t           w_next_state;
   logic             w_load;
   logic             w_last;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-2:0] r_sr;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_done;
   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_sr_full;

   fa_cell u_fa (
      .i_a    (r_sa[0]),
      .i_b    (r_sb[0]),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_c)
   );

   // Newest bit enters at the MSB, so after WIDTH steps this is the full result.
   assign w_sr_full = {w_s, r_sr};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_load       = 1'b1;
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == CNT_LAST) begin
               w_last       = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_sr    <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_sa    <= i_a;
         r_sb    <= i_b ^ {WIDTH{i_sub}};
         r_carry <= i_sub ? 1'b1 : i_cin;
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_sa    <= r_sa >> 1;
         r_sb    <= r_sb >> 1;
         r_sr    <= w_sr_full[WIDTH-1:1];
         r_carry <= w_c;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_last) begin
            r_sum  <= w_sr_full;
            r_cout <= w_c;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // On the last step r_carry is the carry into the MSB and w_c the carry out of it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_ovf <= 1'b0;
      else if (w_last) r_ovf <= r_carry ^ w_c;
   end

   assign o_ovf = r_ovf;
`endif

   assign o_busy      = (r_state == ST_RUN);
   assign o_done      = r_done;
   assign o_sum       = r_sum;
   assign o_cout      = r_cout;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder (WIDTH=8) against an arithmetic model.
module tb_serial_adder;

   localparam int W    = 8;
   localparam int EW   = W + 2;
   localparam int TCLK = 10;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         dbg_state;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  held_sum  = '0;
   logic          held_cout = 1'b0;
   logic          held_ovf  = 1'b0;
   bit            prev_chain = 1'b0;
   time           t_last_done = 0;

   serial_adder #(.WIDTH(W)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_sub       (sub),
      .i_a         (a),
      .i_b         (b),
      .i_cin       (cin),
      .o_busy      (busy),
      .o_done      (done),
      .o_sum       (sum),
      .o_cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
      .o_ovf       (ovf),
`endif
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #(TCLK / 2) clk = ~clk;

   initial begin
      #(200000 * TCLK);
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // Returns {ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
      longint ua, ub, us, ss, smax, smin;
      logic [W-1:0] s;
      logic co, ov;
      ua   = longint'(ma);
      ub   = longint'(mb);
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      if (msub) begin
         us = ua - ub;
         co = (ua >= ub);
         ss = longint'($signed(ma)) - longint'($signed(mb));
      end else begin
         us = ua + ub + longint'(mcin);
         co = (us >= (longint'(1) <<< W));
         ss = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mcin);
      end
      s  = us[W-1:0];
      ov = (ss > smax) || (ss < smin);
      return {ov, co, s};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scramble_inputs();
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'(($urandom));
      sub = 1'(($urandom));
   endtask

   // Called at a negedge. Drives one operation, optionally pokes Start mid-RUN,
   // and optionally leaves the Done cycle open for the caller to chain the next Start.
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                         input logic osub, input bit poke, input bit chain);
      logic [EW-1:0] e;
      start = 1'b1;
      a = oa; b = ob; cin = ocin; sub = osub;
      exp_q.push_back(model(oa, ob, ocin, osub));
      @(negedge clk);
      start = 1'b0;
      scramble_inputs();
      check("busy_first", busy, 1'b1);
      check("hold_sum_first", sum, held_sum);
      for (int j = 1; j < W; j++) begin
         @(negedge clk);
         start = (poke && j == 3);
         scramble_inputs();
         check("run_busy", {busy, done}, 2'b10);
         check("run_hold", {cout, sum}, {held_cout, held_sum});
      end
      @(negedge clk);
      e = exp_q.pop_front();
      check("done_pulse", {done, busy}, 2'b10);
      check("sum", sum, e[W-1:0]);
      check("cout", cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", ovf, e[W+1]);
`endif
      if (prev_chain) check("chain_gap", 64'($time - t_last_done), 64'((W + 1) * TCLK));
      t_last_done = $time;
      held_sum  = e[W-1:0];
      held_cout = e[W];
      held_ovf  = e[W+1];
      prev_chain = chain;
      if (!chain) begin
         @(negedge clk);
         check("done_single", {done, busy}, 2'b00);
         check("post_hold", {cout, sum}, {held_cout, held_sum});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #(TCLK / 4);
      check("reset_outputs", {busy, done, cout, sum}, '0);
      check("reset_state", dbg_state, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      check("plan_5a_3c", {cout, sum}, 9'h096);
      run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      check("plan_ff_01_c1", {cout, sum}, 9'h101);
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      check("plan_10_sub_01", {cout, sum}, 9'h10F);
      run_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
      check("plan_borrow", {cout, sum}, 9'h0FF);

      run_op(8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
      check("poke_ignored", {cout, sum}, 9'h078);

      run_op(8'hC8, 8'h64, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(8'h0A, 8'h14, 1'b0, 1'b1, 1'b0, 1'b0);
      check("chain_second", {cout, sum}, 9'h0F6);

      // Reset during RUN: four RUN edges then reset for one cycle.
      start = 1'b1;
      a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_reset", {busy, done, cout, sum}, '0);
      held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
      prev_chain = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      check("midrun_reset_ovf", ovf, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < W + 2; j++) begin
         @(negedge clk);
         check("no_done_after_reset", {done, busy}, 2'b00);
      end
      run_op(8'h21, 8'h43, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovf_7f_01", {ovf, sum}, 9'h180);
      run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ovf_80_sub_01", {ovf, sum}, 9'h17F);
      run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovf_05_03", {ovf, sum}, 9'h008);
`endif

      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'(($urandom)), 1'(($urandom)),
                ($urandom_range(0, 3) == 0), (i != 39) && ($urandom_range(0, 2) == 0));
      end

      repeat (2) @(negedge clk);
      check("end_idle", {done, busy}, 2'b00);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor; the sequential successor to the single-bit structural full adder.
- Consumes two WIDTH-bit operands, LSB first, one bit per clock, through one full-adder cell; carry is held in a flop between bits.
- Sits beside datapaths where area matters more than latency. Start/Done handshake; result registers hold until the next operation completes.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- Clk  input  1  single clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only while Busy=0.
- Sub  input  1  0 = A+B+Cin, 1 = A-B (B inverted, carry-in forced to 1, Cin ignored); captured at Start.
- A  input  WIDTH  operand A; captured at Start.
- B  input  WIDTH  operand B; captured at Start.
- Cin  input  1  carry-in for add mode; captured at Start.
- Busy  output  1  high while a serial operation is in progress.
- Done  output  1  one-cycle pulse when Sum/Cout are updated.
- Sum  output  WIDTH  result; holds its value between completions.
- Cout  output  1  carry-out; in Sub mode 1 = no borrow.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, internal shift registers, carry flop and counter=0.
- States:
  - IDLE: on Start=1, load A into shift reg SA, load B^{WIDTH{Sub}} into SB, set carry flop = Sub ? 1 : Cin, set counter=0, go to RUN, Busy=1 from the next cycle.
  - RUN: each edge computes {c,s} = FA(SA[0], SB[0], carry). It shifts s into the MSB of result shift reg SR, shifts SA and SB right, sets carry=c and increments the counter. At counter==WIDTH-1 it also loads Sum from {s, SR[WIDTH-1:1]}, sets Cout=c, pulses Done=1, returns to IDLE and sets Busy=0.
- Latency: Start accepted at edge k gives Done=1 and new Sum/Cout visible after edge k+WIDTH. Exactly WIDTH RUN cycles.
- Throughput: Start may be asserted in the same cycle Done is high. It is accepted, giving back-to-back operations with no idle gap, i.e. one result per WIDTH+1 cycles.
- Start while Busy=1 is ignored. No queuing, and operand changes have no effect.
- A/B/Cin/Sub are sampled only at the accepting edge and may change freely afterwards.
- Done is never high for more than one consecutive cycle except with back-to-back operations, where it pulses once per operation.
- Sum/Cout change only on the Done cycle. Intermediate bits are never visible on Sum.
- Reset mid-RUN: immediate return to IDLE with all outputs at reset values. The partial result is discarded and no Done is issued.
- Arithmetic is modulo 2^WIDTH. Cout is the true carry out of bit WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output Ovf (1 bit, reset 0), the signed-overflow flag. Ovf = carry into MSB XOR carry out of MSB, registered with Sum on the Done cycle and held until the next Done.
- Undefined: no Ovf port and no extra flops; behaviour otherwise identical.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - the WIDTH legality check macro.
- Natural sub-module: fa_cell, a one-bit combinational full adder (A, B, Cin -> S, Cout), instantiated once in the datapath.
- Control FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, Cin=0, Sub=0, Start one cycle -> Busy for 8 cycles; Done after edge k+8; Sum=0x96, Cout=0.
- A=0xFF, B=0x01, Cin=1, Sub=0 -> Sum=0x01, Cout=1; then Sub=1, A=0x10, B=0x01 -> Sum=0x0F, Cout=1; and A=0x01, B=0x02, Sub=1 -> Sum=0xFF, Cout=0 (borrow).
- Start re-asserted with different operands during RUN -> ignored; result matches the first operands only; single Done.
- Start held high through the Done cycle with new operands -> second operation accepted with no gap; two Done pulses exactly 9 cycles apart, each with the correct Sum.
- Rst_n low for 1 cycle at RUN bit 4 -> Busy=0, Sum=0, Cout=0 immediately; no Done; next Start completes normally.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> Sum=0x80, Ovf=1; 0x80-0x01 (Sub) -> Sum=0x7F, Ovf=1; 0x05+0x03 -> Ovf=0.
